// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between the fetch and data ports
// of the MIPS core. Data wins by default; a starvation counter forces a fetch
// grant after STARVE_MAX back-to-back data grants while fetch is waiting.
// A wait counter converts a hung memory into an error completion.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | no transaction; grant decision made every cycle
// GRANT_I | fetch in flight, m_req held until m_ack or timeout
// GRANT_D | load/store in flight, m_req held until m_ack or timeout
// RESP    | one-cycle completion pulse on i_ready/d_ready; no grant
module mem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_rdata,
  output logic              i_ready,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ready,
  output logic              err,
  output logic              m_req,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic              m_ack
);

  localparam int WAIT_W   = $clog2(TIMEOUT);
  localparam int STARVE_W = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [WAIT_W-1:0]   WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
  localparam logic [STARVE_W-1:0] STARVE_LIM = STARVE_W'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RESP} state_t;

  state_t              state, state_nxt;
  logic [WAIT_W-1:0]   wait_cnt, wait_cnt_nxt;
  logic [STARVE_W-1:0] starve_cnt, starve_cnt_nxt;

  logic              m_req_nxt, m_we_nxt, i_ready_nxt, d_ready_nxt, err_nxt;
  logic [ADDR_W-1:0] m_addr_nxt;
  logic [DATA_W-1:0] m_wdata_nxt, i_rdata_nxt, d_rdata_nxt;
  logic              done, timed_out;

  // State register; reset drops any in-flight transaction silently
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state, grant decision and completion handling
  always_comb begin
    state_nxt      = state;
    wait_cnt_nxt   = wait_cnt;
    starve_cnt_nxt = starve_cnt;
    m_req_nxt      = m_req;
    m_we_nxt       = m_we;
    m_addr_nxt     = m_addr;
    m_wdata_nxt    = m_wdata;
    i_rdata_nxt    = i_rdata;
    d_rdata_nxt    = d_rdata;
    i_ready_nxt    = 1'b0;
    d_ready_nxt    = 1'b0;
    err_nxt        = 1'b0;
    done           = 1'b0;
    timed_out      = 1'b0;

    case (state)
      IDLE: begin
        if (d_req && (!i_req || (starve_cnt < STARVE_LIM))) begin
          state_nxt    = GRANT_D;
          m_req_nxt    = 1'b1;
          m_we_nxt     = d_we;
          m_addr_nxt   = d_addr;
          m_wdata_nxt  = d_wdata;
          wait_cnt_nxt = '0;
          if (!i_req)                    starve_cnt_nxt = '0;
          else if (starve_cnt != STARVE_LIM) starve_cnt_nxt = starve_cnt + STARVE_W'(1);
        end else if (i_req) begin
          state_nxt      = GRANT_I;
          m_req_nxt      = 1'b1;
          m_we_nxt       = 1'b0;
          m_addr_nxt     = i_addr;
          m_wdata_nxt    = '0;
          wait_cnt_nxt   = '0;
          starve_cnt_nxt = '0;
        end
      end

      GRANT_I, GRANT_D: begin
        // A late ack in the timeout cycle still counts as success
        if (m_ack) begin
          done = 1'b1;
          if (state == GRANT_I) i_rdata_nxt = m_rdata;
          else if (!m_we)       d_rdata_nxt = m_rdata;
        end else if (wait_cnt == WAIT_LAST) begin
          done      = 1'b1;
          timed_out = 1'b1;
          if (state == GRANT_I) i_rdata_nxt = '0;
          else if (!m_we)       d_rdata_nxt = '0;
        end else begin
          wait_cnt_nxt = wait_cnt + WAIT_W'(1);
        end

        if (done) begin
          state_nxt    = RESP;
          m_req_nxt    = 1'b0;
          m_we_nxt     = 1'b0;
          wait_cnt_nxt = '0;
          err_nxt      = timed_out;
          i_ready_nxt  = (state == GRANT_I);
          d_ready_nxt  = (state == GRANT_D);
        end
      end

      RESP: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Registered outputs and counters
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt   <= '0;
      starve_cnt <= '0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      i_rdata    <= '0;
      d_rdata    <= '0;
      i_ready    <= 1'b0;
      d_ready    <= 1'b0;
      err        <= 1'b0;
    end else begin
      wait_cnt   <= wait_cnt_nxt;
      starve_cnt <= starve_cnt_nxt;
      m_req      <= m_req_nxt;
      m_we       <= m_we_nxt;
      m_addr     <= m_addr_nxt;
      m_wdata    <= m_wdata_nxt;
      i_rdata    <= i_rdata_nxt;
      d_rdata    <= d_rdata_nxt;
      i_ready    <= i_ready_nxt;
      d_ready    <= d_ready_nxt;
      err        <= err_nxt;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench. Expected grants and completions are queued
// when a request is driven; a negedge monitor pops and compares them as the
// arbiter raises m_req and the ready pulses.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [31:0] i_rdata, d_rdata, m_addr, m_wdata, m_rdata;
  logic        i_ready, d_ready, err, m_req, m_we, m_ack;

  mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ready(i_ready),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_ready(d_ready), .err(err),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          port_d;
    bit          we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          len;
  } grant_t;

  typedef struct {
    bit          port_d;
    logic [31:0] rdata;
    bit          err;
  } resp_t;

  grant_t grant_q[$];
  resp_t  resp_q[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, expv);
    end
  endtask

  // cycle counter for transaction spacing
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // memory model: acks after mem_wait cycles of m_req
  int          mem_wait  = 0;
  bit          mem_fixed = 1'b1;
  logic [31:0] mem_val   = 32'h0;
  int          mcnt      = 0;

  initial begin
    m_ack   = 1'b0;
    m_rdata = 32'hBAD0BAD0;
    forever begin
      @(negedge clk);
      if (m_req && !reset) begin
        if (mcnt == mem_wait) begin
          m_ack   = 1'b1;
          m_rdata = mem_fixed ? mem_val : ~m_addr;
        end else begin
          m_ack   = 1'b0;
          m_rdata = 32'hBAD0BAD0;
        end
        mcnt++;
      end else begin
        m_ack   = 1'b0;
        m_rdata = 32'hBAD0BAD0;
        mcnt    = 0;
      end
    end
  end

  // monitor
  bit     prev_mreq    = 1'b0;
  int     run_len      = 0;
  grant_t cur_g;
  bit     g_valid      = 1'b0;
  bit     check_period = 1'b0;
  bit     have_start   = 1'b0;
  int     last_start   = 0;
  resp_t  cur_r;

  initial begin
    forever begin
      @(negedge clk);
      if (m_req) begin
        if (!prev_mreq) begin
          if (grant_q.size() == 0) begin
            chk("unexp_grant", 32'(m_req), 32'd0);
            g_valid = 1'b0;
          end else begin
            cur_g   = grant_q.pop_front();
            g_valid = 1'b1;
            chk("m_addr", m_addr, cur_g.addr);
            chk("m_we", 32'(m_we), 32'(cur_g.we));
            chk("m_wdata", m_wdata, cur_g.wdata);
            if (check_period && have_start) chk("period", 32'(cyc - last_start), 32'd3);
            last_start = cyc;
            have_start = 1'b1;
          end
          run_len = 1;
        end else begin
          run_len++;
          if (g_valid) chk("hold_addr", m_addr, cur_g.addr);
        end
      end else if (prev_mreq && g_valid && cur_g.len >= 0) begin
        chk("req_len", 32'(run_len), 32'(cur_g.len));
      end

      if (i_ready || d_ready) begin
        chk("rdy_after_req", 32'({prev_mreq, m_req}), 32'b10);
        if (resp_q.size() == 0) begin
          chk("unexp_ready", 32'({i_ready, d_ready}), 32'd0);
        end else begin
          cur_r = resp_q.pop_front();
          chk("rdy_port", 32'({i_ready, d_ready}), cur_r.port_d ? 32'd1 : 32'd2);
          chk("err", 32'(err), 32'(cur_r.err));
          if (cur_r.port_d) chk("d_rdata", d_rdata, cur_r.rdata);
          else              chk("i_rdata", i_rdata, cur_r.rdata);
        end
      end else begin
        chk("err_idle", 32'(err), 32'd0);
      end
      prev_mreq = m_req;
    end
  end

  task automatic push_exp(input bit pd, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, input int len,
                          input logic [31:0] exp_rd, input bit exp_err);
    grant_t g;
    resp_t  r;
    g.port_d = pd;
    g.we     = pd ? we : 1'b0;
    g.addr   = addr;
    g.wdata  = pd ? wdata : 32'h0;
    g.len    = len;
    grant_q.push_back(g);
    r.port_d = pd;
    r.rdata  = exp_rd;
    r.err    = exp_err;
    resp_q.push_back(r);
  endtask

  // one isolated transaction, request held until its ready pulse
  task automatic txn(input bit pd, input bit we, input logic [31:0] addr,
                     input logic [31:0] wdata, input int mw, input logic [31:0] mv,
                     input logic [31:0] exp_rd, input bit exp_err, input int len);
    int n;
    push_exp(pd, we, addr, wdata, len, exp_rd, exp_err);
    mem_wait  = mw;
    mem_fixed = 1'b1;
    mem_val   = mv;
    if (pd) begin
      d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
    end else begin
      i_req = 1'b1; i_addr = addr; d_wdata = 32'hFFFF0000;
    end
    n = 0;
    while (!(i_ready || d_ready) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_seen", 32'(n < 300), 32'd1);
    i_req  = 1'b0;
    d_req  = 1'b0;
    d_addr = 32'hCAFE0000;
    i_addr = 32'hCAFE0004;
    @(negedge clk);
    chk("drain", 32'(grant_q.size() + resp_q.size()), 32'd0);
  endtask

  initial begin
    int n, dc, ic, di, fi;
    reset = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
    @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_ready", 32'({i_ready, d_ready, err, m_we}), 32'd0);
    chk("rst_rdata", i_rdata | d_rdata | m_wdata, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // single load, two wait cycles
    txn(1'b1, 1'b0, 32'h40, 32'h0, 2, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 3);
    // single store, zero-wait; d_rdata keeps the previous load value
    txn(1'b1, 1'b1, 32'h80, 32'h12345678, 0, 32'h5555AAAA, 32'hDEADBEEF, 1'b0, 1);

    // both requesters busy from reset: 4 data grants then 1 fetch, repeated
    reset = 1'b1;
    mem_fixed = 1'b0;
    mem_wait  = 0;
    di = 0; fi = 0;
    for (int k = 0; k < 10; k++) begin
      if (k % 5 == 4) begin
        push_exp(1'b0, 1'b0, 32'h2000 + 32'(4 * fi), 32'h0, 1, ~(32'h2000 + 32'(4 * fi)), 1'b0);
        fi++;
      end else begin
        push_exp(1'b1, 1'b0, 32'h1000 + 32'(4 * di), 32'h0, 1, ~(32'h1000 + 32'(4 * di)), 1'b0);
        di++;
      end
    end
    i_req = 1'b1; i_addr = 32'h2000;
    d_req = 1'b1; d_addr = 32'h1000; d_we = 1'b0; d_wdata = 32'h0;
    check_period = 1'b1;
    have_start   = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    dc = 0; ic = 0; n = 0;
    while ((dc < 8 || ic < 2) && n < 200) begin
      @(negedge clk);
      n++;
      if (d_ready) begin
        dc++;
        d_addr = d_addr + 32'd4;
        if (dc == 8) d_req = 1'b0;
      end
      if (i_ready) begin
        ic++;
        i_addr = i_addr + 32'd4;
        if (ic == 2) i_req = 1'b0;
      end
    end
    chk("starve_done", 32'(n < 200), 32'd1);
    @(negedge clk);
    check_period = 1'b0;
    chk("starve_drain", 32'(grant_q.size() + resp_q.size()), 32'd0);

    // fetch timeout: m_req exactly 64 cycles, error, zero data
    txn(1'b0, 1'b0, 32'h0, 32'h0, 1000, 32'h5, 32'h0, 1'b1, 64);
    // load timeout clears d_rdata
    txn(1'b1, 1'b0, 32'h44, 32'h9, 1000, 32'h5, 32'h0, 1'b1, 64);
    // ack in the 64th wait cycle wins over the timeout
    txn(1'b0, 1'b0, 32'h0, 32'h0, 63, 32'h5, 32'h5, 1'b0, 64);

    // reset in the middle of a data grant
    grant_q.push_back('{port_d: 1'b1, we: 1'b0, addr: 32'h100, wdata: 32'h77, len: -1});
    mem_wait = 1000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = 32'h77;
    n = 0;
    while (!m_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("mid_grant", 32'(m_req), 32'd1);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("rst_async_mreq", 32'(m_req), 32'd0);
    chk("rst_async_ready", 32'({i_ready, d_ready}), 32'd0);
    d_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("post_rst_ctl", 32'({m_req, m_we, i_ready, d_ready, err}), 32'd0);
    end
    chk("post_rst_addr", m_addr, 32'd0);
    chk("post_rst_data", m_wdata | i_rdata | d_rdata, 32'd0);
    chk("post_rst_q", 32'(grant_q.size() + resp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
